ring_decoder: RTL

RING_DECODER -- requirements
Module: ring_decoder

---
 rtl/ring_decoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ring_decoder.sv
// One-hot ring sequence decoder: validates rotate-right ring codes, locks after LOCK_COUNT
// in-sequence samples and counts lock losses. Define RING_DEC_STALL_EN to tolerate repeated samples.
module ring_decoder #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_en,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     err_clr,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     onehot_ok,
  output logic                     locked,
  output logic                     seq_err,
  output logic [7:0]               err_count
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]    LOCK_MAX = CW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] last_r;
  logic [IW-1:0]    index_r;
  logic             onehot_ok_r;
  logic             locked_r;
  logic             seq_err_r;
  logic [7:0]       err_count_r;

  logic             valid_s;
  logic [IW-1:0]    pos_s;
  logic [WIDTH-1:0] succ_s;
  logic             in_seq_s;
  logic             stall_s;
  logic             loss_s;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - ONE_W)) == '0);
  endfunction

  function automatic logic [IW-1:0] hot_pos(input logic [WIDTH-1:0] v);
    logic [IW-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        p = IW'(i);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Sample classification against the last accepted code
  always_comb begin
    valid_s  = is_onehot(ring_in);
    pos_s    = hot_pos(ring_in);
    succ_s   = {last_r[0], last_r[WIDTH-1:1]};
    in_seq_s = valid_s && (ring_in == succ_s);
`ifdef RING_DEC_STALL_EN
    stall_s  = valid_s && (ring_in == last_r) && (state_r != SEARCH);
`else
    stall_s  = 1'b0;
`endif
    loss_s   = in_en && (state_r == LOCKED) && !stall_s && !in_seq_s;
  end

  // Decoder FSM, match counter, error counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= SEARCH;
      cnt_r       <= '0;
      last_r      <= '0;
      index_r     <= '0;
      onehot_ok_r <= 1'b0;
      locked_r    <= 1'b0;
      seq_err_r   <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      seq_err_r <= loss_s;
      if (err_clr) begin
        err_count_r <= 8'd0;
      end else if (loss_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end else begin
        err_count_r <= err_count_r;
      end

      if (in_en) begin
        onehot_ok_r <= valid_s;
        if (valid_s) begin
          index_r <= pos_s;
        end else begin
          index_r <= index_r;
        end
        case (state_r)
          SEARCH: begin
            if (valid_s) begin
              last_r  <= ring_in;
              cnt_r   <= CW'(1);
              state_r <= TRACK;
            end else begin
              cnt_r   <= '0;
            end
          end
          TRACK: begin
            if (!valid_s) begin
              cnt_r   <= '0;
              state_r <= SEARCH;
            end else if (stall_s) begin
              cnt_r   <= cnt_r;
            end else if (in_seq_s) begin
              last_r <= ring_in;
              cnt_r  <= cnt_r + CW'(1);
              if (cnt_r + CW'(1) == LOCK_MAX) begin
                state_r  <= LOCKED;
                locked_r <= 1'b1;
              end else begin
                state_r  <= TRACK;
              end
            end else begin
              last_r <= ring_in;
              cnt_r  <= CW'(1);
            end
          end
          LOCKED: begin
            if (stall_s) begin
              state_r <= LOCKED;
            end else if (in_seq_s) begin
              last_r  <= ring_in;
            end else begin
              cnt_r    <= '0;
              state_r  <= SEARCH;
              locked_r <= 1'b0;
            end
          end
          default: begin
            cnt_r    <= '0;
            state_r  <= SEARCH;
            locked_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign index     = index_r;
  assign onehot_ok = onehot_ok_r;
  assign locked    = locked_r;
  assign seq_err   = seq_err_r;
  assign err_count = err_count_r;

endmodule
